// File: rtl/fp_sig_capture_if.sv
// Bus bundle for fp_sig_capture.
//   master : drives start/res_valid/res_data, observes status and signature
//   slave  : the capture block (consumes results, presents status/signature)
// When FP_SIG_NAN_COUNT_EN is defined the bundle also carries nan_cnt.
interface fp_sig_capture_if #(
    parameter int unsigned BITWIDTH = 32
);
    logic                start;
    logic                res_valid;
    logic [BITWIDTH-1:0] res_data;
    logic                busy;
    logic                done;
    logic [BITWIDTH-1:0] signature;
    logic [15:0]         sample_cnt;
`ifdef FP_SIG_NAN_COUNT_EN
    logic [15:0]         nan_cnt;

    modport master (
        output start, res_valid, res_data,
        input  busy, done, signature, sample_cnt, nan_cnt
    );
    modport slave (
        input  start, res_valid, res_data,
        output busy, done, signature, sample_cnt, nan_cnt
    );
`else
    modport master (
        output start, res_valid, res_data,
        input  busy, done, signature, sample_cnt
    );
    modport slave (
        input  start, res_valid, res_data,
        output busy, done, signature, sample_cnt
    );
`endif
endinterface

// File: rtl/fp_sig_capture.sv
// Compacts a stream of fp_addsub result words into a MISR signature.
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus.start      - begin a run (accepted in IDLE or DONE)
//   bus.res_valid  - res_data carries a result this cycle
//   bus.res_data   - IEEE-754 single result word
//   bus.busy       - high while a run is in progress
//   bus.done       - high once NUM_SAMPLES results have been absorbed
//   bus.signature  - current MISR value
//   bus.sample_cnt - results absorbed this run
//   bus.nan_cnt    - NaN results absorbed this run (FP_SIG_NAN_COUNT_EN only)
// Optional feature macro: FP_SIG_NAN_COUNT_EN enables the saturating NaN counter.
module fp_sig_capture #(
    parameter int unsigned BITWIDTH    = 32,
    parameter int unsigned NUM_SAMPLES = 256,
    parameter logic [31:0] MISR_POLY   = 32'h04C11DB7,
    parameter logic [31:0] MISR_SEED   = 32'h00000000
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_sig_capture_if.slave  bus
);

    localparam int unsigned CNT_W = 16;
    localparam logic [BITWIDTH-1:0] POLY = BITWIDTH'(MISR_POLY);
    localparam logic [BITWIDTH-1:0] SEED = BITWIDTH'(MISR_SEED);
    localparam logic [CNT_W-1:0]    LAST = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic                busy_q;
    logic                done_q;
    logic [BITWIDTH-1:0] sig_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_vld;
    logic [BITWIDTH-1:0] in_dat;
    logic                start_acc_c;
    logic                absorb_c;
    logic [BITWIDTH-1:0] sig_next_c;

    // A start in RUN is ignored; in IDLE or DONE it launches a new run.
    assign start_acc_c = bus.start && (state != RUN);
    assign absorb_c    = (state == RUN) && in_vld;
    assign sig_next_c  = {sig_q[BITWIDTH-2:0], 1'b0}
                       ^ (sig_q[BITWIDTH-1] ? POLY : '0)
                       ^ in_dat;

    // Input stage; a result presented alongside an accepted start is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld <= 1'b0;
            in_dat <= '0;
        end else begin
            in_vld <= bus.res_valid && !start_acc_c;
            in_dat <= bus.res_data;
        end
    end

    // Run control, signature and sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sig_q  <= SEED;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        sig_q  <= SEED;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    if (in_vld) begin
                        sig_q <= sig_next_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Counter stops at NUM_SAMPLES because RUN is left here.
                        if (cnt_q == LAST) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.signature  = sig_q;
    assign bus.sample_cnt = cnt_q;

`ifdef FP_SIG_NAN_COUNT_EN
    localparam int unsigned MANT_W = 23;
    localparam int unsigned EXP_W  = 8;

    logic [CNT_W-1:0] nan_q;
    logic             is_nan_c;

    // NaN: exponent all ones with a nonzero mantissa (infinities excluded).
    assign is_nan_c = (in_dat[MANT_W +: EXP_W] == {EXP_W{1'b1}})
                   && (in_dat[MANT_W-1:0] != '0);

    // Saturating NaN counter, cleared whenever a run is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q <= '0;
        end else if (start_acc_c) begin
            nan_q <= '0;
        end else if (absorb_c && is_nan_c && (nan_q != {CNT_W{1'b1}})) begin
            nan_q <= nan_q + CNT_W'(1);
        end
    end

    assign bus.nan_cnt = nan_q;
`endif

endmodule

// File: tb/tb_fp_sig_capture.sv
module tb_fp_sig_capture;

    localparam int unsigned NS = 4;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'h00000000;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] cnt;
        logic [15:0] nan;
    } exp_t;

    bit   clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   done_q = 1'b0;

    fp_sig_capture_if #(.BITWIDTH(32)) bus ();

    fp_sig_capture #(
        .BITWIDTH   (32),
        .NUM_SAMPLES(NS),
        .MISR_POLY  (POLY),
        .MISR_SEED  (SEED)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference MISR: multiply signature by x modulo the polynomial, then add the word.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
        logic [32:0] t;
        t = {1'b0, s} * 33'd2;
        if (t >= 33'h1_0000_0000) t = t - 33'h1_0000_0000 + {1'b0, POLY} - {1'b0, POLY} ;
        return (t[31:0] ^ ((t[32] || s[31]) ? POLY : 32'h0)) ^ d;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] w [NS], input int n);
        logic [31:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = misr_step(s, w[i]);
        return s;
    endfunction

    function automatic logic [15:0] nan_ref(input logic [31:0] w [NS]);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < NS; i++)
            if (w[i][30:23] == 8'hFF && w[i][22:0] != 23'd0 && n != 16'hFFFF) n++;
        return n;
    endfunction

    // One full run: start (optionally with a junk result in the start cycle),
    // then NS results separated by random idle gaps.
    task automatic run_seq(input logic [31:0] w [NS], input bit junk, input logic [31:0] junk_data);
        exp_t e;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.res_valid = junk;
        bus.res_data  = junk_data;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
        chk("run_busy", 32'(bus.busy), 32'd1);
        e.sig = misr_ref(w, NS);
        e.cnt = 16'(NS);
        e.nan = nan_ref(w);
        sb.push_back(e);
        for (int i = 0; i < NS; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.res_valid = 1'b0;
                bus.res_data  = $urandom;
                @(posedge clk); #1;
            end
            bus.res_valid = 1'b1;
            bus.res_data  = w[i];
            @(posedge clk); #1;
        end
        bus.res_valid = 1'b0;
        chk("last_pending_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        chk("done_after_last", 32'(bus.done), 32'd1);
        chk("busy_after_last", 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard monitor: each rising done must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_q = 1'b0;
        end else begin
            if (bus.done && !done_q) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_signature", bus.signature, e.sig);
                    chk("sb_sample_cnt", 32'(bus.sample_cnt), 32'(e.cnt));
`ifdef FP_SIG_NAN_COUNT_EN
                    chk("sb_nan_cnt", 32'(bus.nan_cnt), 32'(e.nan));
`endif
                end
            end
            done_q = bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w [NS];
        logic [31:0] a, b;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_signature", bus.signature, 32'h0);
        chk("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        w = '{32'h00000001, 32'h0, 32'h0, 32'h0};
        run_seq(w, 1'b0, 32'h0);
        chk("basic_signature", bus.signature, 32'h00000008);
        chk("basic_sample_cnt", 32'(bus.sample_cnt), 32'd4);

        w = '{32'h80000000, 32'h0, 32'h0, 32'h0};
        run_seq(w, 1'b0, 32'h0);
        chk("poly_signature", bus.signature, 32'h130476DC);

        w = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_seq(w, 1'b1, 32'hFFFFFFFF);
        chk("start_discard_signature", bus.signature, 32'h0);

        // Results arriving in DONE are ignored.
        for (int i = 0; i < 3; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = $urandom | 32'h1;
            @(posedge clk); #1;
        end
        bus.res_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_hold_signature", bus.signature, 32'h0);
        chk("done_hold_sample_cnt", 32'(bus.sample_cnt), 32'd4);
        chk("done_hold_done", 32'(bus.done), 32'd1);
        w = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_seq(w, 1'b0, 32'h0);
        chk("rerun_signature", bus.signature, 32'h0);
        chk("rerun_sample_cnt", 32'(bus.sample_cnt), 32'd4);

        w = '{32'h7FC00000, 32'h7F800000, 32'hFF800001, 32'h3F800000};
        run_seq(w, 1'b0, 32'h0);
`ifdef FP_SIG_NAN_COUNT_EN
        chk("nan_cnt_vector", 32'(bus.nan_cnt), 32'd2);
`endif

        // Mid-run: start ignored, then reset abandons the run.
        a = $urandom | 32'h80000000;
        b = $urandom;
        w = '{a, b, 32'h0, 32'h0};
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_data  = a;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        @(posedge clk); #1;
        bus.res_valid = 1'b1;
        bus.res_data  = b;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("midrun_sample_cnt", 32'(bus.sample_cnt), 32'd2);
        chk("midrun_busy", 32'(bus.busy), 32'd1);
        chk("midrun_signature", bus.signature, misr_ref(w, 2));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_signature", bus.signature, 32'h0);
        chk("midrst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised runs; some words forced to NaN or infinity patterns.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NS; i++) begin
                w[i] = $urandom;
                case ($urandom_range(0, 5))
                    0: w[i][30:23] = 8'hFF;
                    1: begin w[i][30:23] = 8'hFF; w[i][22:0] = 23'd0; end
                    default: ;
                endcase
            end
            run_seq(w, 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
